// File: rtl/hacd_pkg.sv
// Shared types and constants for the HAWK CPU address-translation path.
// Address and ID widths default the per-channel gates to the system AXI bus.
package hacd_pkg;

  localparam int HACD_AXI4_ADDR_WIDTH = 32;
  localparam int HACD_AXI4_ID_WIDTH   = 4;
  localparam int PG_OFF_W             = 12;
  localparam int HACD_PPA_W           = HACD_AXI4_ADDR_WIDTH - PG_OFF_W;

  typedef struct packed {
    logic                  valid;
    logic [HACD_PPA_W-1:0] hppa;
    logic                  zeroBlkWr;
  } cpu_reqpkt_t;

  typedef struct packed {
    logic [HACD_PPA_W-1:0] ppa;
    logic                  allow_access;
  } hawk_cpu_ovrd_pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    ISSUE
  } xlat_state_e;

endpackage

// File: rtl/hawk_xlat_cache1.sv
// Single-entry hppa->ppa translation register with fill, flush and a combinational hit.
// Flush has priority over fill so an ATT update can never be overwritten by a stale grant.
module hawk_xlat_cache1 #(
  parameter int PN_W = 20
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fill_i,
  input  logic [PN_W-1:0] fill_hppa_i,
  input  logic [PN_W-1:0] fill_ppa_i,
  input  logic            flush_i,
  input  logic [PN_W-1:0] lookup_hppa_i,
  output logic            hit_o,
  output logic [PN_W-1:0] ppa_o
);

  logic            vld_q;
  logic [PN_W-1:0] hppa_q;
  logic [PN_W-1:0] ppa_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      hppa_q <= '0;
      ppa_q  <= '0;
    end else if (flush_i) begin
      vld_q <= 1'b0;
    end else if (fill_i) begin
      vld_q  <= 1'b1;
      hppa_q <= fill_hppa_i;
      ppa_q  <= fill_ppa_i;
    end
  end

  assign hit_o = vld_q && (hppa_q == lookup_hppa_i);
  assign ppa_o = ppa_q;

endmodule

// File: rtl/hawk_cpu_addr_xlat.sv
// Per-channel CPU address gate: holds one AXI address beat, obtains its PPA from the
// control unit (or the last-translation register) and issues the translated beat downstream.
module hawk_cpu_addr_xlat
  import hacd_pkg::*;
#(
  parameter int ADDR_W = HACD_AXI4_ADDR_WIDTH,
  parameter int ID_W   = HACD_AXI4_ID_WIDTH,
  parameter bit IS_WR  = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [ADDR_W-1:0]  s_addr,
  input  logic [ID_W-1:0]    s_id,
  input  logic [7:0]         s_len,
  input  logic               s_zero_blk,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [ADDR_W-1:0]  m_addr,
  output logic [ID_W-1:0]    m_id,
  output logic [7:0]         m_len,
  output cpu_reqpkt_t        cpu_reqpkt,
  input  hawk_cpu_ovrd_pkt_t ovrd_pkt,
  input  logic               xlat_flush,
  output logic               busy
);

  localparam int PN_W = ADDR_W - PG_OFF_W;

  xlat_state_e       state_q, state_d;
  logic              sReady_q, sReady_d;
  logic              mValid_q, mValid_d;
  logic              reqValid_q, reqValid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        len_q, len_d;
  logic              zeroBlk_q, zeroBlk_d;
  logic [PN_W-1:0]   ppa_q, ppa_d;

  logic              zeroIn;
  logic              cacheHit;
  logic [PN_W-1:0]   cachePpa;
  logic              cacheFill;

  assign zeroIn = IS_WR ? s_zero_blk : 1'b0;

  hawk_xlat_cache1 #(
    .PN_W(PN_W)
  ) u_cache (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fill_i        (cacheFill),
    .fill_hppa_i   (addr_q[ADDR_W-1:PG_OFF_W]),
    .fill_ppa_i    (ovrd_pkt.ppa),
    .flush_i       (xlat_flush),
    .lookup_hppa_i (s_addr[ADDR_W-1:PG_OFF_W]),
    .hit_o         (cacheHit),
    .ppa_o         (cachePpa)
  );

  // Zero-block writes and same-cycle flushes always go to the control unit.
  always_comb begin
    state_d    = state_q;
    sReady_d   = sReady_q;
    mValid_d   = mValid_q;
    reqValid_d = reqValid_q;
    addr_d     = addr_q;
    id_d       = id_q;
    len_d      = len_q;
    zeroBlk_d  = zeroBlk_q;
    ppa_d      = ppa_q;
    cacheFill  = 1'b0;
    case (state_q)
      IDLE: begin
        sReady_d = 1'b1;
        if (s_valid && sReady_q) begin
          addr_d    = s_addr;
          id_d      = s_id;
          len_d     = s_len;
          zeroBlk_d = zeroIn;
          sReady_d  = 1'b0;
          if (cacheHit && !zeroIn && !xlat_flush) begin
            ppa_d    = cachePpa;
            mValid_d = 1'b1;
            state_d  = ISSUE;
          end else begin
            reqValid_d = 1'b1;
            state_d    = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (ovrd_pkt.allow_access) begin
          ppa_d      = ovrd_pkt.ppa;
          reqValid_d = 1'b0;
          mValid_d   = 1'b1;
          cacheFill  = !xlat_flush;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ready) begin
          mValid_d = 1'b0;
          sReady_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        sReady_d   = 1'b0;
        mValid_d   = 1'b0;
        reqValid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      sReady_q   <= 1'b0;
      mValid_q   <= 1'b0;
      reqValid_q <= 1'b0;
      addr_q     <= '0;
      id_q       <= '0;
      len_q      <= '0;
      zeroBlk_q  <= 1'b0;
      ppa_q      <= '0;
    end else begin
      state_q    <= state_d;
      sReady_q   <= sReady_d;
      mValid_q   <= mValid_d;
      reqValid_q <= reqValid_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      len_q      <= len_d;
      zeroBlk_q  <= zeroBlk_d;
      ppa_q      <= ppa_d;
    end
  end

  assign s_ready    = sReady_q;
  assign m_valid    = mValid_q;
  assign m_addr     = {ppa_q, addr_q[PG_OFF_W-1:0]};
  assign m_id       = id_q;
  assign m_len      = len_q;
  assign cpu_reqpkt = {reqValid_q, addr_q[ADDR_W-1:PG_OFF_W], zeroBlk_q};
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_hawk_cpu_addr_xlat.sv
// Self-checking bench for the AW-flavoured address gate: directed vector table,
// hand-written corner sequences and a randomized run against a page-cache model.
module tb_hawk_cpu_addr_xlat;
  import hacd_pkg::*;

  logic               clk;
  logic               rst_ni;
  logic               sValid;
  logic               sReady;
  logic [31:0]        sAddr;
  logic [3:0]         sId;
  logic [7:0]         sLen;
  logic               sZeroBlk;
  logic               mValid;
  logic               mReady;
  logic [31:0]        mAddr;
  logic [3:0]         mId;
  logic [7:0]         mLen;
  cpu_reqpkt_t        cpuReqpkt;
  hawk_cpu_ovrd_pkt_t ovrdPkt;
  logic               xlatFlush;
  logic               busy;

  int compared = 0;
  int mismatched = 0;

  // Reference page cache: what the last completed lookup taught the gate.
  bit          mVld = 0;
  logic [19:0] mHppa = '0;
  logic [19:0] mPpa = '0;

  hawk_cpu_addr_xlat #(
    .ADDR_W(32),
    .ID_W  (4),
    .IS_WR (1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .s_valid    (sValid),
    .s_ready    (sReady),
    .s_addr     (sAddr),
    .s_id       (sId),
    .s_len      (sLen),
    .s_zero_blk (sZeroBlk),
    .m_valid    (mValid),
    .m_ready    (mReady),
    .m_addr     (mAddr),
    .m_id       (mId),
    .m_len      (mLen),
    .cpu_reqpkt (cpuReqpkt),
    .ovrd_pkt   (ovrdPkt),
    .xlat_flush (xlatFlush),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic        zero;
    logic [19:0] ppa;
    int          gdelay;
    int          rdelay;
    bit          flushBefore;
    bit          flushWithGrant;
    bit          stray;
    bit          expLookup;
    logic [31:0] expAddr;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic doFlush();
    xlatFlush = 1'b1;
    @(negedge clk);
    xlatFlush = 1'b0;
    mVld = 0;
  endtask

  // One complete beat: accept, optional lookup/grant, optional downstream stall, handshake.
  task automatic applyStimulus(input vec_t v, input string tag);
    int waitCnt;
    waitCnt = 0;
    while (!sReady && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({tag, " s_ready before accept"}, 64'(sReady), 64'd1);
    sValid = 1'b1;
    sAddr = v.addr;
    sId = v.id;
    sLen = v.len;
    sZeroBlk = v.zero;
    @(negedge clk);
    sValid = 1'b0;
    sZeroBlk = 1'b0;
    if (v.expLookup) begin
      checkOutput({tag, " reqpkt.valid"}, 64'(cpuReqpkt.valid), 64'd1);
      checkOutput({tag, " reqpkt.hppa"}, 64'(cpuReqpkt.hppa), 64'(v.addr[31:12]));
      checkOutput({tag, " reqpkt.zeroBlkWr"}, 64'(cpuReqpkt.zeroBlkWr), 64'(v.zero));
      checkOutput({tag, " m_valid in lookup"}, 64'(mValid), 64'd0);
      for (int i = 0; i < v.gdelay; i++) begin
        @(negedge clk);
        checkOutput({tag, " reqpkt.valid held"}, 64'(cpuReqpkt.valid), 64'd1);
      end
      ovrdPkt.allow_access = 1'b1;
      ovrdPkt.ppa = v.ppa;
      xlatFlush = v.flushWithGrant;
      @(negedge clk);
      ovrdPkt = '0;
      xlatFlush = 1'b0;
      checkOutput({tag, " reqpkt.valid dropped"}, 64'(cpuReqpkt.valid), 64'd0);
    end else begin
      checkOutput({tag, " reqpkt.valid on hit"}, 64'(cpuReqpkt.valid), 64'd0);
    end
    checkOutput({tag, " m_valid"}, 64'(mValid), 64'd1);
    checkOutput({tag, " m_addr"}, 64'(mAddr), 64'(v.expAddr));
    checkOutput({tag, " m_id"}, 64'(mId), 64'(v.id));
    checkOutput({tag, " m_len"}, 64'(mLen), 64'(v.len));
    for (int i = 0; i < v.rdelay; i++) begin
      if (v.stray && i == 0) begin
        ovrdPkt.allow_access = 1'b1;
        ovrdPkt.ppa = '1;
      end
      @(negedge clk);
      ovrdPkt = '0;
      checkOutput({tag, " stall m_valid"}, 64'(mValid), 64'd1);
      checkOutput({tag, " stall m_addr"}, 64'(mAddr), 64'(v.expAddr));
      checkOutput({tag, " stall s_ready"}, 64'(sReady), 64'd0);
    end
    mReady = 1'b1;
    @(negedge clk);
    mReady = 1'b0;
    checkOutput({tag, " m_valid after handshake"}, 64'(mValid), 64'd0);
    checkOutput({tag, " s_ready after handshake"}, 64'(sReady), 64'd1);
    if (v.expLookup) begin
      if (v.flushWithGrant) mVld = 0;
      else begin
        mVld = 1;
        mHppa = v.addr[31:12];
        mPpa = v.ppa;
      end
    end
  endtask

  initial begin
    logic [19:0] hpool[3];
    vec_t rv;
    hpool = '{20'h80001, 20'h12345, 20'h00000};

    //                addr          id    len    z     ppa       gd rd fb fg st lk expAddr
    vecs[0] = '{32'h8000_1234, 4'h1, 8'h03, 1'b0, 20'h00042, 3, 0, 0, 0, 0, 1, 32'h0004_2234};
    vecs[1] = '{32'h8000_1040, 4'h2, 8'h00, 1'b0, 20'h00000, 0, 1, 0, 0, 0, 0, 32'h0004_2040};
    vecs[2] = '{32'h8000_1040, 4'h3, 8'h07, 1'b0, 20'h00077, 1, 0, 1, 0, 0, 1, 32'h0007_7040};
    vecs[3] = '{32'h8000_1080, 4'h4, 8'h01, 1'b1, 20'h00099, 2, 0, 0, 0, 0, 1, 32'h0009_9080};
    vecs[4] = '{32'h8000_1FFC, 4'h5, 8'hFF, 1'b0, 20'h00000, 0, 5, 0, 0, 1, 0, 32'h0009_9FFC};
    vecs[5] = '{32'h1234_5678, 4'h6, 8'h0F, 1'b0, 20'h00ABC, 0, 0, 0, 1, 0, 1, 32'h00AB_C678};
    vecs[6] = '{32'h1234_5000, 4'h7, 8'h02, 1'b0, 20'h00DEF, 2, 2, 0, 0, 0, 1, 32'h00DE_F000};
    vecs[7] = '{32'h1234_5FFF, 4'h8, 8'h04, 1'b0, 20'h00000, 0, 0, 0, 0, 0, 0, 32'h00DE_FFFF};

    rst_ni = 1'b0;
    sValid = 1'b1;
    sAddr = 32'h8000_1234;
    sId = '0;
    sLen = '0;
    sZeroBlk = 1'b0;
    mReady = 1'b0;
    ovrdPkt = '0;
    xlatFlush = 1'b0;

    // Reset held with a pending beat: nothing may be accepted or issued.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset s_ready", 64'(sReady), 64'd0);
      checkOutput("reset m_valid", 64'(mValid), 64'd0);
      checkOutput("reset reqpkt.valid", 64'(cpuReqpkt.valid), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
    end
    sValid = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].flushBefore) doFlush();
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // allow_access while idle must be ignored.
    ovrdPkt.allow_access = 1'b1;
    ovrdPkt.ppa = 20'h55555;
    @(negedge clk);
    ovrdPkt = '0;
    checkOutput("idle stray busy", 64'(busy), 64'd0);
    checkOutput("idle stray s_ready", 64'(sReady), 64'd1);
    checkOutput("idle stray reqpkt.valid", 64'(cpuReqpkt.valid), 64'd0);
    checkOutput("idle stray m_valid", 64'(mValid), 64'd0);

    // Reset in the middle of a lookup drops the beat.
    sValid = 1'b1;
    sAddr = 32'hABCD_E123;
    sZeroBlk = 1'b1;
    @(negedge clk);
    sValid = 1'b0;
    sZeroBlk = 1'b0;
    checkOutput("midreset lookup entered", 64'(cpuReqpkt.valid), 64'd1);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    checkOutput("midreset s_ready", 64'(sReady), 64'd0);
    checkOutput("midreset m_valid", 64'(mValid), 64'd0);
    checkOutput("midreset reqpkt.valid", 64'(cpuReqpkt.valid), 64'd0);
    checkOutput("midreset busy", 64'(busy), 64'd0);
    mVld = 0;
    @(negedge clk);
    checkOutput("post-reset s_ready", 64'(sReady), 64'd1);

    // Randomized beats against the page-cache model.
    for (int n = 0; n < 60; n++) begin
      logic [19:0] hp;
      hp = hpool[$urandom_range(0, 2)];
      rv.addr = {hp, 12'($urandom())};
      rv.id = 4'($urandom());
      rv.len = 8'($urandom());
      rv.zero = ($urandom_range(0, 4) == 0);
      rv.ppa = 20'($urandom());
      rv.gdelay = $urandom_range(0, 4);
      rv.rdelay = $urandom_range(0, 3);
      rv.flushBefore = ($urandom_range(0, 5) == 0);
      rv.flushWithGrant = ($urandom_range(0, 5) == 0);
      rv.stray = ($urandom_range(0, 3) == 0);
      if (rv.flushBefore) doFlush();
      rv.expLookup = rv.zero || !(mVld && mHppa == hp);
      rv.expAddr = rv.expLookup ? {rv.ppa, rv.addr[11:0]} : {mPpa, rv.addr[11:0]};
      applyStimulus(rv, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
